render_sequencer: RTL and testbench

RENDER_SEQUENCER -- requirements
Module: render_sequencer

---
 rtl/render_sequencer_pkg.sv | 23 ++
 rtl/frame_timer.sv | 31 +++
 rtl/render_sequencer.sv | 155 +++++++++++++++
 tb/tb_render_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/render_sequencer_pkg.sv
// rtl/render_sequencer_pkg.sv - shared state encoding and pixel-bus constants for the render sequencer
package render_sequencer_pkg;

  // Sequencer phases: one START cycle, per-layer DRAW, one UPDATE cycle, HOLD until the frame period ends
  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_DRAW   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_HOLD   = 2'd3
  } seq_state_t;

  // Pixel-bus widths of the 160x120 VGA adapter
  localparam int DEF_X_W     = 8;
  localparam int DEF_Y_W     = 7;
  localparam int DEF_COLOR_W = 3;

  // One frame at 60 Hz from a 50 MHz system clock
  localparam int DEF_FRAME_CYCLES = 833333;

  // cur_layer is 3 bits wide, so at most eight draw clients
  localparam int MAX_LAYERS = 8;

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - saturating frame-period counter with synchronous clear and terminal flag
module frame_timer
  import render_sequencer_pkg::*;
#(
  parameter int FRAME_CYCLES = DEF_FRAME_CYCLES
) (
  input  logic Clock,
  input  logic resetn,
  input  logic clear,
  output logic terminal
);

  localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Count up every cycle, stick at the last value, restart from zero on clear
  always_ff @(posedge Clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + CNT_W'(1);
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/render_sequencer.sv
// rtl/render_sequencer.sv - frame sequencer granting draw layers in order and advancing the scroll position
module render_sequencer
  import render_sequencer_pkg::*;
#(
  parameter int NUM_LAYERS   = 3,
  parameter int POS_WIDTH    = 32,
  parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int X_W          = DEF_X_W,
  parameter int Y_W          = DEF_Y_W,
  parameter int COLOR_W      = DEF_COLOR_W
) (
  input  logic                          Clock,
  input  logic                          resetn,
  input  logic [NUM_LAYERS-1:0]         skip_mask,
  input  logic                          pause,
  input  logic [3:0]                    step,
  input  logic [NUM_LAYERS-1:0]         layer_done,
  input  logic [NUM_LAYERS*X_W-1:0]     layer_x,
  input  logic [NUM_LAYERS*Y_W-1:0]     layer_y,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
  input  logic [NUM_LAYERS-1:0]         layer_plot,
  output logic [NUM_LAYERS-1:0]         layer_enable,
  output logic [X_W-1:0]                x,
  output logic [Y_W-1:0]                y,
  output logic [COLOR_W-1:0]            color,
  output logic                          plot,
  output logic [POS_WIDTH-1:0]          position,
  output logic                          frame_start,
  output logic [2:0]                    cur_layer
);

  seq_state_t             state, state_d;
  logic [2:0]             idx, idx_d;
  logic [NUM_LAYERS-1:0]  mask_q, mask_d;
  logic [POS_WIDTH-1:0]   pos_d;
  logic [3:0]             search;
  logic                   done_cur;
  logic                   timer_clear;
  logic                   timer_done;

  // Lowest non-skipped layer at or above 'from'; bit 3 flags that one exists
  function automatic logic [3:0] next_layer(input logic [NUM_LAYERS-1:0] skip,
                                            input logic [3:0]            from);
    logic [3:0] result;
    result = 4'd0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if ((i >= int'(from)) && !skip[i]) begin
        result = {1'b1, 3'(i)};
      end
    end
    return result;
  endfunction

  // Cleared on the HOLD->START edge so the timer reads zero during START
  frame_timer #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_frame_timer (
    .Clock    (Clock),
    .resetn   (resetn),
    .clear    (timer_clear),
    .terminal (timer_done)
  );

  // Sequencer state, active layer, latched skip mask and scroll position
  always_ff @(posedge Clock or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_START;
      idx      <= 3'd0;
      mask_q   <= '0;
      position <= '0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      mask_q   <= mask_d;
      position <= pos_d;
    end
  end

  // Next-state logic: layer walk, scroll update and frame pacing
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    mask_d      = mask_q;
    pos_d       = position;
    timer_clear = 1'b0;
    search      = 4'd0;
    case (state)
      ST_START: begin
        mask_d = skip_mask;
        search = next_layer(skip_mask, 4'd0);
        if (search[3]) begin
          idx_d   = search[2:0];
          state_d = ST_DRAW;
        end else begin
          idx_d   = 3'd0;
          state_d = ST_UPDATE;
        end
      end
      ST_DRAW: begin
        if (done_cur) begin
          search = next_layer(mask_q, {1'b0, idx} + 4'd1);
          if (search[3]) begin
            idx_d = search[2:0];
          end else begin
            idx_d   = 3'd0;
            state_d = ST_UPDATE;
          end
        end
      end
      ST_UPDATE: begin
        if (!pause) begin
          pos_d = position + POS_WIDTH'(step);
        end
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (timer_done) begin
          timer_clear = 1'b1;
          state_d     = ST_START;
        end
      end
      default: begin
        state_d = ST_START;
      end
    endcase
  end

  // Grant and pixel mux for the active layer; everything reads zero outside DRAW
  always_comb begin
    layer_enable = '0;
    x            = '0;
    y            = '0;
    color        = '0;
    plot         = 1'b0;
    done_cur     = 1'b0;
    if (state == ST_DRAW) begin
      for (int k = 0; k < NUM_LAYERS; k++) begin
        if (idx == 3'(k)) begin
          layer_enable[k] = 1'b1;
          x               = layer_x[k*X_W +: X_W];
          y               = layer_y[k*Y_W +: Y_W];
          color           = layer_color[k*COLOR_W +: COLOR_W];
          plot            = layer_plot[k];
          done_cur        = layer_done[k];
        end
      end
    end
  end

  assign cur_layer = (state == ST_DRAW) ? idx : 3'd0;

  // Reset parks the FSM in START; gating with resetn keeps the pulse quiet until reset is released
  assign frame_start = (state == ST_START) && resetn;

endmodule

// File: tb/tb_render_sequencer.sv
// tb/tb_render_sequencer.sv - directed self-checking bench for render_sequencer
module tb_render_sequencer;

  localparam int NL = 3;
  localparam int PW = 4;
  localparam int FC = 16;

  localparam logic [7:0] XV [3] = '{8'h11, 8'h52, 8'hA3};
  localparam logic [6:0] YV [3] = '{7'h05, 7'h3A, 7'h7F};
  localparam logic [2:0] CV [3] = '{3'd5, 3'd2, 3'd7};

  logic           Clock = 1'b0;
  logic           resetn;
  logic [NL-1:0]  skip_mask;
  logic           pause;
  logic [3:0]     step;
  logic [NL-1:0]  layer_done;
  logic [NL*8-1:0] layer_x;
  logic [NL*7-1:0] layer_y;
  logic [NL*3-1:0] layer_color;
  logic [NL-1:0]  layer_plot;
  logic [NL-1:0]  layer_enable;
  logic [7:0]     x;
  logic [6:0]     y;
  logic [2:0]     color;
  logic           plot;
  logic [PW-1:0]  position;
  logic           frame_start;
  logic [2:0]     cur_layer;

  int             checks = 0;
  int             errors = 0;

  int             need [3];
  int             cnt [3] = '{0, 0, 0};
  logic [NL-1:0]  done_force;
  logic [NL-1:0]  done_model;

  int             f_len;
  logic [23:0]    f_ord;
  int             f_en [3];
  int             f_bad;

  render_sequencer #(
    .NUM_LAYERS   (NL),
    .POS_WIDTH    (PW),
    .FRAME_CYCLES (FC),
    .X_W          (8),
    .Y_W          (7),
    .COLOR_W      (3)
  ) dut (
    .Clock        (Clock),
    .resetn       (resetn),
    .skip_mask    (skip_mask),
    .pause        (pause),
    .step         (step),
    .layer_done   (layer_done),
    .layer_x      (layer_x),
    .layer_y      (layer_y),
    .layer_color  (layer_color),
    .layer_plot   (layer_plot),
    .layer_enable (layer_enable),
    .x            (x),
    .y            (y),
    .color        (color),
    .plot         (plot),
    .position     (position),
    .frame_start  (frame_start),
    .cur_layer    (cur_layer)
  );

  always #5 Clock = ~Clock;

  assign layer_x     = {XV[2], XV[1], XV[0]};
  assign layer_y     = {YV[2], YV[1], YV[0]};
  assign layer_color = {CV[2], CV[1], CV[0]};
  assign layer_plot  = 3'b111;

  // Client model: a granted layer raises done on its need-th enabled cycle
  always @(posedge Clock) begin
    for (int k = 0; k < NL; k++) begin
      cnt[k] <= layer_enable[k] ? cnt[k] + 1 : 0;
    end
  end

  always_comb begin
    done_model = '0;
    for (int k = 0; k < NL; k++) begin
      done_model[k] = layer_enable[k] && (cnt[k] == need[k] - 1);
    end
  end

  assign layer_done = done_model | done_force;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Follows one frame from its START sample to the next frame_start, recording grants and bus behaviour
  task automatic trace(input int chg_at, input logic chg_pause, input logic [3:0] chg_step);
    logic [2:0] en;
    logic [2:0] last;
    int         k;
    f_len = 0;
    f_ord = '0;
    f_bad = 0;
    last  = 3'b000;
    for (int i = 0; i < 3; i++) f_en[i] = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge Clock);
      if (chg_at != 0 && n == chg_at) begin
        pause = chg_pause;
        step  = chg_step;
      end
      if (frame_start) begin
        if (layer_enable !== 3'b000 || plot !== 1'b0) f_bad++;
        f_len = n;
        break;
      end
      en = layer_enable;
      k  = int'(cur_layer);
      if (en != 3'b000) begin
        if (en != last) f_ord = {f_ord[20:0], en};
        if (k < NL) begin
          f_en[k]++;
          if (en !== 3'(1 << k) || x !== XV[k] || y !== YV[k] || color !== CV[k] || plot !== 1'b1)
            f_bad++;
        end else begin
          f_bad++;
        end
      end else if (x !== 8'h00 || y !== 7'h00 || color !== 3'h0 || plot !== 1'b0 || cur_layer !== 3'd0) begin
        f_bad++;
      end
      last = en;
    end
  endtask

  task automatic expect_frame(input string tag, input int len, input logic [23:0] ord,
                              input logic [23:0] enw, input logic [3:0] pos);
    check({tag, "_period"}, 64'(f_len), 64'(len));
    check({tag, "_grant_order"}, 64'(f_ord), 64'(ord));
    check({tag, "_grant_cycles"}, 64'({8'(f_en[0]), 8'(f_en[1]), 8'(f_en[2])}), 64'(enw));
    check({tag, "_bus_errors"}, 64'(f_bad), 64'd0);
    check({tag, "_position"}, 64'(position), 64'(pos));
  endtask

  initial begin
    resetn     = 1'b0;
    skip_mask  = 3'b000;
    pause      = 1'b1;
    step       = 4'd0;
    done_force = 3'b000;
    need       = '{2, 2, 2};

    repeat (2) @(negedge Clock);
    check("rst_frame_start", 64'(frame_start), 64'd0);
    check("rst_enable", 64'(layer_enable), 64'd0);
    check("rst_plot", 64'(plot), 64'd0);
    check("rst_x", 64'(x), 64'd0);
    check("rst_position", 64'(position), 64'd0);
    check("rst_cur_layer", 64'(cur_layer), 64'd0);

    @(negedge Clock);
    resetn = 1'b1;
    #1;
    check("first_frame_start", 64'(frame_start), 64'd1);

    // All layers, paused: grants 0,1,2 for two cycles each, period FC
    trace(0, 1'b0, 4'd0);
    expect_frame("A", FC, 24'o124, 24'h020202, 4'd0);

    // Layer 1 skipped, scroll by 13
    skip_mask = 3'b010; pause = 1'b0; step = 4'd13;
    trace(0, 1'b0, 4'd0);
    expect_frame("B", FC, 24'o14, 24'h020002, 4'd13);

    // Values set at START are replaced mid-DRAW; UPDATE sees 13+5 wrapping to 2
    skip_mask = 3'b000; pause = 1'b1; step = 4'd15;
    trace(3, 1'b0, 4'd5);
    expect_frame("C", FC, 24'o124, 24'h020202, 4'd2);

    // Paused for three frames with a nonzero step
    pause = 1'b1; step = 4'd9;
    for (int i = 0; i < 3; i++) begin
      trace(0, 1'b0, 4'd0);
      check("pause_hold_position", 64'(position), 64'd2);
    end

    // Every layer skipped: no grants, position still advances each frame
    skip_mask = 3'b111; pause = 1'b0; step = 4'd3;
    trace(0, 1'b0, 4'd0);
    expect_frame("G", FC, 24'o0, 24'h000000, 4'd5);
    trace(0, 1'b0, 4'd0);
    expect_frame("H", FC, 24'o0, 24'h000000, 4'd8);

    // Drawing overruns the period: 1 + 40 + 1 + 1 cycles
    skip_mask = 3'b000; pause = 1'b1; need = '{14, 13, 13};
    trace(0, 1'b0, 4'd0);
    expect_frame("I", 43, 24'o124, 24'h0E0D0D, 4'd8);

    // Layer 1 holds done continuously: granted one cycle, ignored while others draw
    need = '{2, 2, 2}; done_force = 3'b010;
    trace(0, 1'b0, 4'd0);
    expect_frame("J", FC, 24'o124, 24'h020102, 4'd8);

    // Reset pulsed while layer 1 is drawing
    done_force = 3'b000; need = '{2, 5, 2};
    repeat (3) @(negedge Clock);
    check("pre_rst_enable", 64'(layer_enable), 64'b010);
    check("pre_rst_cur_layer", 64'(cur_layer), 64'd1);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_enable", 64'(layer_enable), 64'd0);
    check("mid_rst_plot", 64'(plot), 64'd0);
    check("mid_rst_pixel", 64'({x, y, color}), 64'd0);
    check("mid_rst_cur_layer", 64'(cur_layer), 64'd0);
    check("mid_rst_position", 64'(position), 64'd0);
    check("mid_rst_frame_start", 64'(frame_start), 64'd0);
    @(negedge Clock);
    resetn = 1'b1;
    #1;
    check("restart_frame_start", 64'(frame_start), 64'd1);
    @(negedge Clock);
    check("restart_enable", 64'(layer_enable), 64'b001);
    check("restart_cur_layer", 64'(cur_layer), 64'd0);
    check("restart_frame_start_low", 64'(frame_start), 64'd0);
    check("restart_x", 64'(x), 64'(XV[0]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
